// File: rtl/fpu_arbiter.sv
// Two-requester round-robin arbiter in front of a single fpu. It latches the winner's
// command, holds the fpu ready/valid handshake, and returns the result with a done pulse.
module fpu_arbiter #(
  parameter int TIMEOUT    = 1024,
  parameter bit FIRST_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r0_req,
  input  logic [5:0]  r0_op,
  input  logic [4:0]  r0_x1,
  input  logic [4:0]  r0_x2,
  input  logic [4:0]  r0_y,
  input  logic [31:0] r0_data,
  output logic        r0_ack,
  output logic        r0_done,
  input  logic        r1_req,
  input  logic [5:0]  r1_op,
  input  logic [4:0]  r1_x1,
  input  logic [4:0]  r1_x2,
  input  logic [4:0]  r1_y,
  input  logic [31:0] r1_data,
  output logic        r1_ack,
  output logic        r1_done,
  output logic [31:0] rsp_data,
  output logic        rsp_cond,
  output logic        rsp_err,
  output logic [5:0]  fpu_operation,
  output logic [4:0]  fpu_x1,
  output logic [4:0]  fpu_x2,
  output logic [4:0]  fpu_y,
  output logic [31:0] fpu_in_data,
  output logic        fpu_ready,
  input  logic        fpu_valid,
  input  logic [31:0] fpu_out_data,
  input  logic        fpu_cond
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state, state_d;
  logic          owner, owner_d;
  logic          last_grant, last_grant_d;
  logic [TW-1:0] wd, wd_d;

  logic          r0_ack_d, r1_ack_d, r0_done_d, r1_done_d;
  logic [31:0]   rsp_data_d;
  logic          rsp_cond_d, rsp_err_d;
  logic [5:0]    fpu_operation_d;
  logic [4:0]    fpu_x1_d, fpu_x2_d, fpu_y_d;
  logic [31:0]   fpu_in_data_d;
  logic          fpu_ready_d;

  logic          any_req;
  logic          pick;

  // Watchdog never wraps: it parks on its last value even if the state logic lingers.
  function automatic logic [TW-1:0] wd_inc(input logic [TW-1:0] v);
    return (v == WD_LAST) ? v : v + 1'b1;
  endfunction

  // With both requesting, the one not served last time wins; otherwise the sole requester.
  assign any_req = r0_req | r1_req;
  assign pick    = (r0_req & r1_req) ? ~last_grant : r1_req;

  always_comb begin
    state_d         = state;
    owner_d         = owner;
    last_grant_d    = last_grant;
    wd_d            = wd;
    r0_ack_d        = 1'b0;
    r1_ack_d        = 1'b0;
    r0_done_d       = 1'b0;
    r1_done_d       = 1'b0;
    rsp_data_d      = rsp_data;
    rsp_cond_d      = rsp_cond;
    rsp_err_d       = rsp_err;
    fpu_operation_d = fpu_operation;
    fpu_x1_d        = fpu_x1;
    fpu_x2_d        = fpu_x2;
    fpu_y_d         = fpu_y;
    fpu_in_data_d   = fpu_in_data;
    fpu_ready_d     = fpu_ready;

    unique case (state)
      IDLE: begin
        if (any_req) begin
          fpu_operation_d = pick ? r1_op   : r0_op;
          fpu_x1_d        = pick ? r1_x1   : r0_x1;
          fpu_x2_d        = pick ? r1_x2   : r0_x2;
          fpu_y_d         = pick ? r1_y    : r0_y;
          fpu_in_data_d   = pick ? r1_data : r0_data;
          r0_ack_d        = ~pick;
          r1_ack_d        = pick;
          fpu_ready_d     = 1'b1;
          owner_d         = pick;
          last_grant_d    = pick;
          wd_d            = '0;
          state_d         = BUSY;
        end
      end
      BUSY: begin
        wd_d = wd_inc(wd);
        // A result arriving on the watchdog's final cycle still counts as a completion.
        if (fpu_valid) begin
          rsp_data_d  = fpu_out_data;
          rsp_cond_d  = fpu_cond;
          rsp_err_d   = 1'b0;
          r0_done_d   = ~owner;
          r1_done_d   = owner;
          fpu_ready_d = 1'b0;
          state_d     = RESP;
        end else if (wd == WD_LAST) begin
          rsp_data_d  = '0;
          rsp_cond_d  = 1'b0;
          rsp_err_d   = 1'b1;
          r0_done_d   = ~owner;
          r1_done_d   = owner;
          fpu_ready_d = 1'b0;
          state_d     = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        fpu_ready_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      owner         <= 1'b0;
      last_grant    <= ~FIRST_PRIO;
      wd            <= '0;
      r0_ack        <= 1'b0;
      r1_ack        <= 1'b0;
      r0_done       <= 1'b0;
      r1_done       <= 1'b0;
      rsp_data      <= '0;
      rsp_cond      <= 1'b0;
      rsp_err       <= 1'b0;
      fpu_operation <= '0;
      fpu_x1        <= '0;
      fpu_x2        <= '0;
      fpu_y         <= '0;
      fpu_in_data   <= '0;
      fpu_ready     <= 1'b0;
    end else begin
      state         <= state_d;
      owner         <= owner_d;
      last_grant    <= last_grant_d;
      wd            <= wd_d;
      r0_ack        <= r0_ack_d;
      r1_ack        <= r1_ack_d;
      r0_done       <= r0_done_d;
      r1_done       <= r1_done_d;
      rsp_data      <= rsp_data_d;
      rsp_cond      <= rsp_cond_d;
      rsp_err       <= rsp_err_d;
      fpu_operation <= fpu_operation_d;
      fpu_x1        <= fpu_x1_d;
      fpu_x2        <= fpu_x2_d;
      fpu_y         <= fpu_y_d;
      fpu_in_data   <= fpu_in_data_d;
      fpu_ready     <= fpu_ready_d;
    end
  end

endmodule
